// File: rtl/pong_pkg.sv
// Shared screen geometry, colour constants and FSM encoding for the pong
// graphics block.
package pong_pkg;

    localparam logic [9:0] HPIX     = 10'd640;
    localparam logic [9:0] VPIX     = 10'd480;
    localparam logic [9:0] TICK_Y   = 10'd481;

    localparam logic [9:0] WALL_L   = 10'd32;
    localparam logic [9:0] WALL_R   = 10'd39;
    localparam logic [9:0] PAD_L    = 10'd600;
    localparam logic [9:0] PAD_R    = 10'd603;

    localparam logic [9:0] TOP_LIM  = 10'd2;
    localparam logic [9:0] BOT_LIM  = 10'd477;
    localparam logic [9:0] WALL_LIM = 10'd40;
    localparam logic [9:0] MISS_LIM = 10'd631;

    localparam logic [9:0] SERVE_X  = 10'd316;
    localparam logic [9:0] SERVE_Y  = 10'd236;
    localparam logic [9:0] PAD_Y0   = 10'd204;

    localparam logic [11:0] COL_OFF  = 12'h000;
    localparam logic [11:0] COL_WALL = 12'h00F;
    localparam logic [11:0] COL_PAD  = 12'h0F0;
    localparam logic [11:0] COL_BALL = 12'hF00;
    localparam logic [11:0] COL_BG   = 12'h111;

    typedef enum logic [1:0] {StServe, StPlay, StMiss, StOver} state_e;

    function automatic logic in_range(input logic [9:0] v, input logic [9:0] lo,
                                      input logic [9:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/pong_ball.sv
// Ball position, per-axis direction bits and collision detection. Outside PLAY
// the ball is parked at the serve position on every frame tick.
module pong_ball
    import pong_pkg::*;
#(
    parameter int unsigned BALL_SIZE = 8,
    parameter int unsigned PAD_H     = 72,
    parameter int unsigned BALL_V    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick_i,
    input  logic       play_i,
    input  logic [9:0] pad_y_i,
    output logic [9:0] ball_x_o,
    output logic [9:0] ball_y_o,
    output logic       hit_o,
    output logic       miss_o
);

    localparam logic [9:0] BallV  = 10'(BALL_V);
    localparam logic [9:0] BallS1 = 10'(BALL_SIZE - 1);
    localparam logic [9:0] PadH1  = 10'(PAD_H - 1);

    logic [9:0] ball_x_q, ball_y_q, nx, ny;
    logic       vx_q, vx_d, vy_q, vy_d;
    logic       pad_hit;

    // Direction bit 1 means moving towards larger coordinates.
    always_comb begin
        nx      = vx_q ? ball_x_q + BallV : ball_x_q - BallV;
        ny      = vy_q ? ball_y_q + BallV : ball_y_q - BallV;
        pad_hit = vx_q && in_range(nx + BallS1, PAD_L, PAD_R)
                  && (ny <= pad_y_i + PadH1) && (ny + BallS1 >= pad_y_i);
        vx_d = vx_q;
        vy_d = vy_q;
        if (ny <= TOP_LIM) begin
            vy_d = 1'b1;
        end else if (ny + BallS1 >= BOT_LIM) begin
            vy_d = 1'b0;
        end
        if (nx <= WALL_LIM) begin
            vx_d = 1'b1;
        end
        if (pad_hit) begin
            vx_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ball_x_q <= SERVE_X;
            ball_y_q <= SERVE_Y;
            vx_q     <= 1'b0;
            vy_q     <= 1'b1;
        end else if (frame_tick_i) begin
            if (play_i) begin
                ball_x_q <= nx;
                ball_y_q <= ny;
                vx_q     <= vx_d;
                vy_q     <= vy_d;
            end else begin
                ball_x_q <= SERVE_X;
                ball_y_q <= SERVE_Y;
                vx_q     <= 1'b0;
                vy_q     <= 1'b1;
            end
        end
    end

    assign ball_x_o = ball_x_q;
    assign ball_y_o = ball_y_q;
    assign hit_o    = frame_tick_i && play_i && pad_hit;
    assign miss_o   = frame_tick_i && play_i && (nx > MISS_LIM);

endmodule

// File: rtl/pong_graphics.sv
// Pong game top: frame tick, paddle, game FSM with hit/miss counters and the
// registered pixel colour mux.
module pong_graphics
    import pong_pkg::*;
#(
    parameter int unsigned BALL_SIZE = 8,
    parameter int unsigned PAD_H     = 72,
    parameter int unsigned PAD_V     = 3,
    parameter int unsigned BALL_V    = 2,
    parameter int unsigned MISS_WAIT = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        btn_up,
    input  logic        btn_down,
    output logic [11:0] rgb,
    output logic [7:0]  hits,
    output logic [1:0]  misses,
    output logic        game_over
);

    localparam logic [9:0] PadV     = 10'(PAD_V);
    localparam logic [9:0] PadMax   = 10'(VPIX - 10'(PAD_H));
    localparam logic [9:0] PadH1    = 10'(PAD_H - 1);
    localparam logic [9:0] BallS1   = 10'(BALL_SIZE - 1);
    localparam logic [7:0] MissLast = 8'(MISS_WAIT - 1);

    state_e      state_q, state_d;
    logic        cond_q, cond_prev_q, frame_tick;
    logic [9:0]  pad_y_q, pad_y_d;
    logic [7:0]  hits_q, hits_d, cnt_q, cnt_d;
    logic [1:0]  misses_q, misses_d;
    logic [11:0] rgb_q, rgb_d;
    logic [9:0]  ball_x, ball_y;
    logic        ball_hit, ball_miss, play, ball_vis;

    assign frame_tick = cond_q && !cond_prev_q;
    assign play       = (state_q == StPlay);
    assign ball_vis   = (state_q == StServe) || (state_q == StPlay);

    pong_ball #(
        .BALL_SIZE (BALL_SIZE),
        .PAD_H     (PAD_H),
        .BALL_V    (BALL_V)
    ) u_ball (
        .clk          (clk),
        .reset        (reset),
        .frame_tick_i (frame_tick),
        .play_i       (play),
        .pad_y_i      (pad_y_q),
        .ball_x_o     (ball_x),
        .ball_y_o     (ball_y),
        .hit_o        (ball_hit),
        .miss_o       (ball_miss)
    );

    always_comb begin
        pad_y_d = pad_y_q;
        if (frame_tick && state_q != StOver) begin
            if (btn_up && !btn_down) begin
                pad_y_d = (pad_y_q < PadV) ? 10'd0 : pad_y_q - PadV;
            end else if (btn_down && !btn_up) begin
                pad_y_d = (pad_y_q > PadMax - PadV) ? PadMax : pad_y_q + PadV;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        hits_d   = hits_q;
        misses_d = misses_q;
        cnt_d    = cnt_q;
        if (frame_tick) begin
            case (state_q)
                StServe: if (btn_up || btn_down) state_d = StPlay;
                StPlay: begin
                    if (ball_hit) hits_d = hits_q + 8'd1;
                    if (ball_miss) begin
                        misses_d = (misses_q == 2'd3) ? 2'd3 : misses_q + 2'd1;
                        cnt_d    = 8'd0;
                        state_d  = (misses_q >= 2'd2) ? StOver : StMiss;
                    end
                end
                StMiss: begin
                    if (cnt_q == MissLast) begin
                        cnt_d   = 8'd0;
                        state_d = StServe;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                StOver: begin
                    if (btn_up && btn_down) begin
                        hits_d   = 8'd0;
                        misses_d = 2'd0;
                        state_d  = StServe;
                    end
                end
                default: state_d = StServe;
            endcase
        end
    end

    // Priority: blanking, wall, paddle, ball, background.
    always_comb begin
        rgb_d = rgb_q;
        if (p_tick) begin
            if (!video_on) begin
                rgb_d = COL_OFF;
            end else if (in_range(x, WALL_L, WALL_R)) begin
                rgb_d = COL_WALL;
            end else if (in_range(x, PAD_L, PAD_R) && in_range(y, pad_y_q, pad_y_q + PadH1)) begin
                rgb_d = COL_PAD;
            end else if (ball_vis && in_range(x, ball_x, ball_x + BallS1)
                         && in_range(y, ball_y, ball_y + BallS1)) begin
                rgb_d = COL_BALL;
            end else begin
                rgb_d = COL_BG;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StServe;
            cond_q      <= 1'b0;
            cond_prev_q <= 1'b0;
            pad_y_q     <= PAD_Y0;
            hits_q      <= 8'd0;
            misses_q    <= 2'd0;
            cnt_q       <= 8'd0;
            rgb_q       <= 12'h000;
        end else begin
            state_q     <= state_d;
            cond_q      <= (x == 10'd0) && (y == TICK_Y);
            cond_prev_q <= cond_q;
            pad_y_q     <= pad_y_d;
            hits_q      <= hits_d;
            misses_q    <= misses_d;
            cnt_q       <= cnt_d;
            rgb_q       <= rgb_d;
        end
    end

    assign rgb       = rgb_q;
    assign hits      = hits_q;
    assign misses    = misses_q;
    assign game_over = (state_q == StOver);

endmodule

// File: tb/tb_pong_graphics.sv
// Directed bench for pong_graphics: frames are emulated by briefly driving the
// (0,481) tick pixel, and single pixels are probed between frames.
module tb_pong_graphics;
    import pong_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        p_tick = 1'b0;
    logic        video_on = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic [9:0]  x = 10'd100;
    logic [9:0]  y = 10'd100;
    logic [11:0] rgb;
    logic [7:0]  hits;
    logic [1:0]  misses;
    logic        game_over;

    int checks = 0;
    int failures = 0;

    always #10 clk = ~clk;

    pong_graphics dut (
        .clk       (clk),
        .reset     (reset),
        .p_tick    (p_tick),
        .video_on  (video_on),
        .x         (x),
        .y         (y),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .rgb       (rgb),
        .hits      (hits),
        .misses    (misses),
        .game_over (game_over)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Tick pixel held for two clocks, as the real 25 MHz timing stage does.
    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            x = 10'd0; y = 10'd481; video_on = 1'b0; p_tick = 1'b0;
            @(negedge clk);
            @(negedge clk);
            x = 10'd1;
            @(negedge clk);
        end
    endtask

    task automatic probe(input string tag, input int px, input int py, input int exp);
        @(negedge clk);
        x = 10'(px); y = 10'(py); video_on = (px < 640) && (py < 480); p_tick = 1'b1;
        @(negedge clk);
        p_tick = 1'b0;
        check_eq(tag, int'(rgb), exp);
    endtask

    // One serve press with btn_down, then the 434-frame trajectory to x=632.
    task automatic serve_and_miss(input int exp_misses);
        btn_down = 1'b1;
        run_frames(1);
        btn_down = 1'b0;
        run_frames(433);
        check_eq("misses_before_edge", int'(misses), exp_misses - 1);
        run_frames(1);
        check_eq("misses_at_edge", int'(misses), exp_misses);
    endtask

    initial begin
        #55;
        check_eq("rst_rgb", int'(rgb), 0);
        check_eq("rst_hits", int'(hits), 0);
        check_eq("rst_misses", int'(misses), 0);
        check_eq("rst_game_over", int'(game_over), 0);
        check_eq("rst_pad_y", int'(dut.pad_y_q), 204);
        @(negedge clk);
        reset = 1'b1;

        run_frames(1);
        probe("px_bg", 320, 100, 12'h111);
        probe("px_wall", 35, 100, 12'h00F);
        probe("px_pad", 601, 210, 12'h0F0);
        @(negedge clk);
        x = 10'd320; y = 10'd100; video_on = 1'b1; p_tick = 1'b0;
        @(negedge clk);
        check_eq("px_hold_no_ptick", int'(rgb), 12'h0F0);
        probe("px_ball", 318, 238, 12'hF00);
        probe("px_blank", 700, 100, 12'h000);

        btn_up = 1'b1;
        run_frames(1);
        check_eq("pad_up_1", int'(dut.pad_y_q), 201);
        run_frames(1);
        check_eq("pad_up_2", int'(dut.pad_y_q), 198);
        check_eq("ball_x_first", int'(dut.u_ball.ball_x_q), 314);
        check_eq("ball_y_first", int'(dut.u_ball.ball_y_q), 238);
        probe("px_ball_moved", 314, 238, 12'hF00);
        probe("px_ball_left", 322, 240, 12'h111);
        run_frames(65);
        check_eq("pad_up_67", int'(dut.pad_y_q), 3);
        run_frames(3);
        check_eq("pad_clamp_0", int'(dut.pad_y_q), 0);
        btn_up = 1'b0;

        btn_down = 1'b1;
        run_frames(33);
        btn_up = 1'b1;
        run_frames(5);
        check_eq("pad_both_hold", int'(dut.pad_y_q), 99);
        btn_up = 1'b0; btn_down = 1'b0;

        run_frames(31);
        check_eq("ball_at_wall", int'(dut.u_ball.ball_x_q), 40);
        run_frames(1);
        check_eq("ball_after_wall", int'(dut.u_ball.ball_x_q), 42);

        run_frames(275);
        check_eq("hits_before", int'(hits), 0);
        check_eq("ball_x_pre_hit", int'(dut.u_ball.ball_x_q), 592);
        run_frames(1);
        check_eq("hits_after", int'(hits), 1);
        check_eq("ball_x_hit", int'(dut.u_ball.ball_x_q), 594);
        check_eq("ball_y_hit", int'(dut.u_ball.ball_y_q), 130);
        probe("px_ball_at_pad", 596, 132, 12'hF00);
        probe("px_pad_over_ball", 601, 132, 12'h0F0);

        btn_down = 1'b1;
        run_frames(1);
        check_eq("ball_x_bounced", int'(dut.u_ball.ball_x_q), 592);
        run_frames(29);
        btn_down = 1'b0;
        check_eq("pad_down_30", int'(dut.pad_y_q), 189);
        run_frames(542);
        check_eq("misses_pre", int'(misses), 0);
        run_frames(1);
        check_eq("misses_1", int'(misses), 1);
        check_eq("state_miss", int'(dut.state_q), int'(StMiss));
        check_eq("hits_kept", int'(hits), 1);
        run_frames(1);
        probe("px_ball_hidden_miss", 318, 238, 12'h111);
        run_frames(58);
        check_eq("state_miss_59", int'(dut.state_q), int'(StMiss));
        run_frames(1);
        check_eq("state_serve_60", int'(dut.state_q), int'(StServe));
        probe("px_ball_serve", 318, 238, 12'hF00);

        serve_and_miss(2);
        check_eq("state_miss_2", int'(dut.state_q), int'(StMiss));
        check_eq("pad_serve_2", int'(dut.pad_y_q), 192);
        run_frames(60);
        check_eq("state_serve_2", int'(dut.state_q), int'(StServe));

        serve_and_miss(3);
        check_eq("game_over_set", int'(game_over), 1);
        probe("px_ball_hidden_over", 318, 238, 12'h111);
        btn_up = 1'b1;
        run_frames(1);
        check_eq("pad_frozen_over", int'(dut.pad_y_q), 195);
        check_eq("game_over_hold", int'(game_over), 1);
        btn_down = 1'b1;
        run_frames(1);
        btn_up = 1'b0; btn_down = 1'b0;
        check_eq("clr_hits", int'(hits), 0);
        check_eq("clr_misses", int'(misses), 0);
        check_eq("clr_game_over", int'(game_over), 0);
        check_eq("clr_state", int'(dut.state_q), int'(StServe));

        serve_and_miss(1);
        run_frames(10);
        probe("px_wall_pre_rst", 35, 100, 12'h00F);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("mrst_rgb", int'(rgb), 0);
        check_eq("mrst_misses", int'(misses), 0);
        check_eq("mrst_hits", int'(hits), 0);
        check_eq("mrst_game_over", int'(game_over), 0);
        check_eq("mrst_pad_y", int'(dut.pad_y_q), 204);
        check_eq("mrst_state", int'(dut.state_q), int'(StServe));
        @(negedge clk);
        reset = 1'b1;
        run_frames(3);
        check_eq("idle_state", int'(dut.state_q), int'(StServe));
        check_eq("idle_ball_x", int'(dut.u_ball.ball_x_q), 316);
        probe("px_ball_idle", 318, 238, 12'hF00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pong_graphics.md
PONG_GRAPHICS -- requirements
Module: pong_graphics

Interface
REQ-001 Parameter BALL_SIZE, default 8: ball square edge, pixels.
REQ-002 Parameter PAD_H, default 72: paddle height, pixels.
REQ-003 Parameter PAD_V, default 3: paddle step, pixels/frame.
REQ-004 Parameter BALL_V, default 2: ball speed per axis, pixels/frame.
REQ-005 Parameter MISS_WAIT, default 60: frames held in MISS.
REQ-006 clk  in  1  system clock, 50 MHz; the only clock.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 p_tick  in  1  25 MHz pixel-rate signal from the VGA timing stage.
REQ-009 video_on  in  1  high inside the 640x480 display area.
REQ-010 x  in  10  current pixel column, 0-799.
REQ-011 y  in  10  current pixel row, 0-524.
REQ-012 btn_up, btn_down  in  1 each  paddle buttons, synchronous active-high, already debounced.
REQ-013 rgb  out  12  pixel colour, 4 bits each of R, G and B.
REQ-014 hits  out  8  paddle-hit count, wraps 255->0.
REQ-015 misses  out  2  miss count, saturates at 3.
REQ-016 game_over  out  1  high in the OVER state.

Function
REQ-017 frame_tick shall be a one-clk pulse on the first clk where (x==0 && y==481) becomes true, using an edge detect on the registered condition.
REQ-018 All ball, paddle and FSM state shall update only on frame_tick.
REQ-019 Geometry: wall x 32-39 spanning full height; paddle x 600-603 at top row pad_y; ball occupies ball_x..ball_x+BALL_SIZE-1 by ball_y..ball_y+BALL_SIZE-1.
REQ-020 Paddle: btn_up alone sets pad_y -= PAD_V, clamped at 0; btn_down alone sets pad_y += PAD_V, clamped at 480-PAD_H; both or neither leaves pad_y unchanged; the paddle moves in every state except OVER.
REQ-021 FSM states are SERVE, PLAY, MISS and OVER.
REQ-022 SERVE: ball at (316,236) with vx=-BALL_V and vy=+BALL_V; any button at frame_tick moves the FSM to PLAY.
REQ-023 PLAY: ball_x += vx and ball_y += vy each frame, then collisions are evaluated on the new position.
REQ-024 Top collision: ball_y <= 2 sets vy=+BALL_V. Bottom collision: ball_y+BALL_SIZE-1 >= 477 sets vy=-BALL_V.
REQ-025 Wall collision: ball_x <= 40 sets vx=+BALL_V.
REQ-026 Paddle hit: ball right edge within 600-603, vx>0 and vertical overlap with the paddle rows sets vx=-BALL_V and increments hits once.
REQ-027 Miss: ball_x > 631 increments misses and moves the FSM to OVER if misses reaches 3, otherwise to MISS.
REQ-028 Simultaneous wall and top/bottom collisions shall both apply in the same frame.
REQ-029 MISS: a frame counter counts MISS_WAIT frames and then the FSM moves to SERVE; the ball is not drawn in MISS.
REQ-030 OVER: the ball is hidden; btn_up && btn_down at frame_tick clears hits and misses and moves the FSM to SERVE.
REQ-031 Colour priority: !video_on gives 12'h000; wall gives 12'h00F; paddle gives 12'h0F0; ball (SERVE/PLAY only) gives 12'hF00; background gives 12'h111.
REQ-032 rgb shall be registered, loaded on clk edges where p_tick==1, with one-clk latency from x/y.
REQ-033 All arithmetic shall be 10-bit unsigned; velocity is held as a direction bit per axis, with no negative intermediates.

Reset
REQ-034 Reset shall set: FSM=SERVE, ball=(316,236), vx=-, vy=+, pad_y=204, hits=0, misses=0, frame counter=0, rgb=0, game_over=0, edge-detect register=0.
REQ-035 Reset asserted mid-frame or mid-MISS shall take effect immediately; play resumes only after a fresh SERVE button press.

Structure
REQ-036 Screen extents, wall/paddle coordinates, colour constants and the state encoding shall live in shared package pong_pkg.
REQ-037 Ball position, velocity and collision logic shall be one sub-module, pong_ball; the paddle, FSM and pixel mux stay in the top module.

Verification
REQ-038 Reset, then drive a full frame with no buttons -> rgb=12'h111 at (320,100), 12'h00F at (35,100), 12'h0F0 at (601,210), 12'hF00 at (318,238), 0 at (700,100).
REQ-039 Hold btn_up for 70 frames -> pad_y steps 204,201,... and stops at 0; both buttons held -> pad_y unchanged.
REQ-040 Press a button in SERVE -> after 1 frame ball=(314,238); after the ball reaches x<=40 -> vx positive on the next frame.
REQ-041 Pad_y aligned with the ball path -> vx flips at the paddle and hits=1; pad_y=0 with the ball low -> misses=1, MISS for 60 frames, then SERVE.
REQ-042 Force three misses -> game_over=1 and the ball is hidden; both buttons pressed -> hits=0, misses=0, SERVE.
REQ-043 Assert reset while in MISS -> all outputs return to REQ-034 values within 1 clk.
